f_param_return: RTL and testbench

- Parametrised successor to the single-return function FSM used for compiled leaf functions.
- Accepts N_ARGS packed arguments of WIDTH bits on a start/done handshake and latches them.
- Returns one of: a selected argument, the wrapping sum of all arguments, or the unsigned maximum.
- Sits under the compiled-function top level as a reusable leaf-call engine.

---
 rtl/f_param_return.sv | 137 +++++++++++++
 tb/tb_f_param_return.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/f_param_return.sv
// Parametrised leaf-call engine: latches N_ARGS packed arguments on a start/done
// handshake and returns a selected argument, their wrapping sum, or the unsigned maximum.
module f_param_return #(
  parameter int WIDTH  = 32,
  parameter int N_ARGS = 2,
  parameter int SEL_W  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_ARGS*WIDTH-1:0]   args,
  input  logic [SEL_W-1:0]          sel,
  input  logic [1:0]                mode,
  output logic [WIDTH-1:0]          result,
  output logic                      done,
  output logic                      busy
);

  localparam int IDX_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ARGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    RUN,
    RET
  } state_t;

  state_t                    state_q, state_d;
  logic [N_ARGS*WIDTH-1:0]   args_q, args_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [1:0]                mode_q, mode_d;
  logic [WIDTH-1:0]          acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [WIDTH-1:0]          result_q, result_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;

  logic [WIDTH-1:0]          arg_arr [N_ARGS];
  logic [WIDTH-1:0]          cur_arg;
  logic [WIDTH-1:0]          sel_arg;
  logic [WIDTH-1:0]          ret_val;

  for (genvar g = 0; g < N_ARGS; g++) begin : g_unpack
    assign arg_arr[g] = args_q[g*WIDTH +: WIDTH];
  end

  // Explicit compares instead of dynamic indexing, so an out-of-range sel yields 0.
  always_comb begin
    cur_arg = '0;
    sel_arg = '0;
    for (int i = 0; i < N_ARGS; i++) begin
      if (32'(idx_q) == i) cur_arg = arg_arr[i];
      if (32'(sel_q) == i) sel_arg = arg_arr[i];
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    ret_val = sel_arg;
      2'd1,
      2'd2:    ret_val = acc_q;
      default: ret_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    args_d   = args_q;
    sel_d    = sel_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    done_d   = done_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LATCH;
          busy_d  = 1'b1;
        end
      end
      LATCH: begin
        args_d  = args;
        sel_d   = sel;
        mode_d  = mode;
        done_d  = 1'b0;
        acc_d   = '0;
        idx_d   = '0;
        state_d = (mode == 2'd1 || mode == 2'd2) ? RUN : RET;
      end
      RUN: begin
        if (mode_q == 2'd1) acc_d = acc_q + cur_arg;
        else                acc_d = (cur_arg > acc_q) ? cur_arg : acc_q;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = RET;
      end
      RET: begin
        result_d = ret_val;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      args_q   <= '0;
      sel_q    <= '0;
      mode_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      args_q   <= args_d;
      sel_q    <= sel_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_f_param_return.sv
// Directed bench for f_param_return (WIDTH=32, N_ARGS=4): scoreboard of expected
// return values, latency/busy/done checks, ignored starts, back-to-back and reset abort.
module tb_f_param_return;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [127:0]  args = '0;
  logic [1:0]    sel = '0;
  logic [1:0]    mode = '0;
  logic [31:0]   result;
  logic          done;
  logic          busy;

  int            total = 0;
  int            bad = 0;
  int            rise_cnt = 0;
  logic          prev_done = 1'b0;
  logic          last_rise = 1'b0;
  logic [31:0]   sb_q [$];

  f_param_return #(.WIDTH(32), .N_ARGS(4), .SEL_W(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .args   (args),
    .sel    (sel),
    .mode   (mode),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    last_rise = done && !prev_done;
    if (last_rise) rise_cnt++;
    prev_done = done;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [127:0] a, input logic [1:0] s, input logic [1:0] m);
    logic [31:0] acc = '0;
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = a[i*32 +: 32];
      if (m == 2'd1) acc = acc + v;
      else if (m == 2'd2 && v > acc) acc = v;
    end
    if (m == 2'd0) return a[32*int'(s) +: 32];
    if (m == 2'd3) return 32'd0;
    return acc;
  endfunction

  // Launches one call, scrambles inputs after the latch edge, optionally pulses
  // start again at edge extra_pulse, and waits (bounded) for the done rise.
  task automatic apply_stimulus(input logic [127:0] a, input logic [1:0] s, input logic [1:0] m,
                                input logic [31:0] expv, input int exp_lat, input int extra_pulse,
                                input string tag);
    int k;
    bit seen;
    logic [31:0] e;
    args = a;
    sel  = s;
    mode = m;
    start = 1'b1;
    sb_q.push_back(expv);
    tick();
    start = 1'b0;
    check_output({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      if (extra_pulse != 0 && k + 1 == extra_pulse) start = 1'b1;
      tick();
      k++;
      start = 1'b0;
      if (k == 1) begin
        args = {$urandom, $urandom, $urandom, $urandom};
        sel  = 2'($urandom);
        mode = 2'($urandom);
      end
      if (last_rise) seen = 1;
      else if (k < exp_lat) check_output({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
    check_output({tag, "_latency"}, 32'(k), 32'(exp_lat));
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout observed=no_done expected=done", tag);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      check_output({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s_sb_empty observed=done expected=queued_result", tag);
      end else begin
        e = sb_q.pop_front();
        check_output({tag, "_result"}, result, e);
      end
    end
  endtask

  initial begin
    int rises;
    logic [127:0] ra;
    $display("[TB] start");

    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("rst_result", result, 32'd0);
      check_output("rst_done", {31'd0, done}, 32'd0);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
    end

    apply_stimulus({32'd4, 32'd3, 32'd2, 32'd1}, 2'd2, 2'd0, 32'd3, 2, 0, "sel2");
    apply_stimulus({32'd4, 32'd3, 32'd2, 32'hFFFF_FFFF}, 2'd0, 2'd1, 32'h0000_0008, 6, 0, "sum_wrap");

    rises = rise_cnt;
    apply_stimulus({32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'd7}, 2'd0, 2'd2, 32'h8000_0000, 6, 3, "max");
    repeat (6) tick();
    check_output("max_one_done", 32'(rise_cnt - rises), 32'd1);
    check_output("max_idle_busy", {31'd0, busy}, 32'd0);

    apply_stimulus({32'd0, 32'd0, 32'd0, 32'd0}, 2'd0, 2'd2, 32'd0, 6, 0, "max_zero");
    apply_stimulus({32'd9, 32'd8, 32'd7, 32'd6}, 2'd1, 2'd3, 32'd0, 2, 0, "mode3");
    apply_stimulus({32'd9, 32'd8, 32'd7, 32'd6}, 2'd3, 2'd0, 32'd9, 2, 0, "sel3");
    ra = {$urandom, $urandom, $urandom, $urandom};
    apply_stimulus(ra, 2'd0, 2'd1, model(ra, 2'd0, 2'd1), 6, 0, "sum_rand");

    // Back-to-back: start held high across two calls.
    args  = {32'd0, 32'd0, 32'd0, 32'd10};
    sel   = 2'd0;
    mode  = 2'd0;
    start = 1'b1;
    sb_q.push_back(32'd10);
    tick();
    tick();
    tick();
    check_output("b2b_first_done", {31'd0, done}, 32'd1);
    check_output("b2b_first_result", result, sb_q.pop_front());
    args = {32'd0, 32'd0, 32'd0, 32'd20};
    sb_q.push_back(32'd20);
    tick();
    check_output("b2b_done_held", {31'd0, done}, 32'd1);
    check_output("b2b_busy2", {31'd0, busy}, 32'd1);
    tick();
    start = 1'b0;
    check_output("b2b_done_drop", {31'd0, done}, 32'd0);
    check_output("b2b_result_hold", result, 32'd10);
    tick();
    check_output("b2b_second_done", {31'd0, done}, 32'd1);
    check_output("b2b_second_result", result, sb_q.pop_front());
    repeat (3) tick();
    check_output("b2b_no_third", {31'd0, busy}, 32'd0);

    // Reset aborts a sum call in RUN; no done may follow.
    rises = rise_cnt;
    args  = {32'd1, 32'd2, 32'd3, 32'd4};
    mode  = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("abort_result", result, 32'd0);
    check_output("abort_done", {31'd0, done}, 32'd0);
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    repeat (8) tick();
    check_output("abort_no_done", 32'(rise_cnt - rises), 32'd0);
    apply_stimulus({32'd44, 32'd33, 32'd22, 32'd11}, 2'd1, 2'd0, 32'd22, 2, 0, "post_abort");

    check_output("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
